// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: register map addresses and FSM states.
package intr_pkg;

  localparam logic [4:0] ADDR_PENDING = 5'd0;
  localparam logic [4:0] ADDR_MASK    = 5'd1;
  localparam logic [4:0] ADDR_STATUS  = 5'd2;
  localparam logic [4:0] ADDR_RAW     = 5'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// Register bus, interrupt lines and CPU handshake of the interrupt controller.
interface intr_ctrl_if;
  logic [7:0] int_in;
  logic [4:0] readaddr;
  logic [7:0] readdata;
  logic [4:0] writeaddr;
  logic [7:0] writedata;
  logic       write_en;
  logic       irq;
  logic [2:0] irq_vector;
  logic       irq_ack;
  logic       irq_done;

  modport slave (
    input  int_in, readaddr, writeaddr, writedata, write_en, irq_ack, irq_done,
    output readdata, irq, irq_vector
  );

  modport master (
    output int_in, readaddr, writeaddr, writedata, write_en, irq_ack, irq_done,
    input  readdata, irq, irq_vector
  );
endinterface

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request bit (bit 0 wins).
module intr_prio_enc (
  input  logic [7:0] req,
  output logic [2:0] index,
  output logic       valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    index = 3'd0;
    valid = |req;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) index = 3'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Single-level interrupt controller with PENDING/MASK registers and IDLE/REQUEST/SERVICE handshake.
// Define INTR_EDGE_DETECT_EN for rising-edge events; level-sensitive otherwise.
module intr_ctrl
  import intr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  intr_ctrl_if.slave  bus
);

  state_t     state;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [2:0] vector;
  logic       irq;
  logic [7:0] readdata;

  logic [7:0] src_event;
  logic [7:0] w1c;
  logic [7:0] ack_clr;
  logic [7:0] pending_nxt;
  logic [7:0] mask_nxt;
  logic       ack_take;
  logic [2:0] enc_index;
  logic       enc_valid;

`ifdef INTR_EDGE_DETECT_EN
  logic [7:0] int_prev;

  always_ff @(posedge clk) begin
    if (reset) int_prev <= 8'd0;
    else       int_prev <= bus.int_in;
  end

  assign src_event = bus.int_in & ~int_prev;
`else
  assign src_event = bus.int_in;
`endif

  assign ack_take = (state == ST_REQUEST) && bus.irq_ack;
  assign w1c      = (bus.write_en && bus.writeaddr == ADDR_PENDING) ? bus.writedata : 8'd0;
  assign ack_clr  = ack_take ? (8'd1 << vector) : 8'd0;

  // Events are OR-ed in last so a new event beats a W1C or ack clear on the same bit.
  assign pending_nxt = (pending & ~w1c & ~ack_clr) | src_event;
  assign mask_nxt    = (bus.write_en && bus.writeaddr == ADDR_MASK) ? bus.writedata : mask;

  intr_prio_enc u_prio_enc (
    .req   (pending & mask),
    .index (enc_index),
    .valid (enc_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 8'd0;
      mask    <= 8'd0;
    end else begin
      pending <= pending_nxt;
      mask    <= mask_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      vector <= 3'd0;
      irq    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            vector <= enc_index;
            irq    <= 1'b1;
            state  <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          // Ack takes priority; otherwise retract as soon as the source is cleared or masked.
          if (ack_take) begin
            irq   <= 1'b0;
            state <= ST_SERVICE;
          end else if (!(pending_nxt[vector] && mask_nxt[vector])) begin
            irq   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (bus.irq_done) state <= ST_IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 8'd0;
    end else begin
      case (bus.readaddr)
        ADDR_PENDING: readdata <= pending;
        ADDR_MASK:    readdata <= mask;
        ADDR_STATUS:  readdata <= {state == ST_SERVICE, state == ST_REQUEST, 3'b000, vector};
        ADDR_RAW:     readdata <= bus.int_in;
        default:      readdata <= 8'd0;
      endcase
    end
  end

  assign bus.irq        = irq;
  assign bus.irq_vector = vector;
  assign bus.readdata   = readdata;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios then random traffic against a cycle model.
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  intr_ctrl_if bus ();

  intr_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model: registers plus a "requesting" / "in service" flag pair.
  logic [7:0] m_pend, m_mask, m_rd;
  logic       m_req, m_svc;
  logic [2:0] m_vec;
`ifdef INTR_EDGE_DETECT_EN
  logic [7:0] m_prev;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [7:0] ev, w1c, clr, pend_n, mask_n;
    int lo;
    if (reset) begin
      m_pend = 8'd0; m_mask = 8'd0; m_rd = 8'd0;
      m_req = 1'b0;  m_svc = 1'b0;  m_vec = 3'd0;
`ifdef INTR_EDGE_DETECT_EN
      m_prev = 8'd0;
`endif
      return;
    end
    case (bus.readaddr)
      5'd0:    m_rd = m_pend;
      5'd1:    m_rd = m_mask;
      5'd2:    m_rd = {m_svc, m_req, 3'b000, m_vec};
      5'd3:    m_rd = bus.int_in;
      default: m_rd = 8'd0;
    endcase
`ifdef INTR_EDGE_DETECT_EN
    ev     = bus.int_in & ~m_prev;
    m_prev = bus.int_in;
`else
    ev = bus.int_in;
`endif
    w1c = (bus.write_en && bus.writeaddr == 5'd0) ? bus.writedata : 8'd0;
    clr = 8'd0;
    if (m_req && bus.irq_ack) clr[m_vec] = 1'b1;
    pend_n = (m_pend & ~w1c & ~clr) | ev;
    mask_n = (bus.write_en && bus.writeaddr == 5'd1) ? bus.writedata : m_mask;
    if (!m_req && !m_svc) begin
      lo = -1;
      for (int i = 0; i < 8; i++)
        if (lo < 0 && m_pend[i] && m_mask[i]) lo = i;
      if (lo >= 0) begin
        m_req = 1'b1;
        m_vec = 3'(lo);
      end
    end else if (m_req) begin
      if (bus.irq_ack) begin
        m_req = 1'b0;
        m_svc = 1'b1;
      end else if (!(pend_n[m_vec] && mask_n[m_vec])) begin
        m_req = 1'b0;
      end
    end else if (bus.irq_done) begin
      m_svc = 1'b0;
    end
    m_pend = pend_n;
    m_mask = mask_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("irq", 32'(bus.irq), 32'(m_req));
    check("irq_vector", 32'(bus.irq_vector), 32'(m_vec));
    check("readdata", 32'(bus.readdata), 32'(m_rd));
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] data);
    bus.write_en  = 1'b1;
    bus.writeaddr = addr;
    bus.writedata = data;
    step();
    bus.write_en  = 1'b0;
  endtask

  initial begin
    int services;
    reset = 1'b1;
    bus.int_in = 8'd0; bus.readaddr = 5'd0; bus.writeaddr = 5'd0; bus.writedata = 8'd0;
    bus.write_en = 1'b0; bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
    step();
    step();
    check("reset_irq", 32'(bus.irq), 32'd0);
    check("reset_readdata", 32'(bus.readdata), 32'd0);
    reset = 1'b0;

    // Single source, two-cycle latency, ack and done
    wr(5'd1, 8'h01);
    bus.int_in = 8'h01; step();
    check("lat_irq_cycle1", 32'(bus.irq), 32'd0);
    bus.int_in = 8'h00; step();
    check("lat_irq_cycle2", 32'(bus.irq), 32'd1);
    check("lat_vector", 32'(bus.irq_vector), 32'd0);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    bus.readaddr = 5'd2; step();
    check("svc_status", 32'(bus.readdata), 32'h80);
    bus.readaddr = 5'd0; step();
    check("svc_pending", 32'(bus.readdata), 32'h00);
    bus.irq_done = 1'b1; step(); bus.irq_done = 1'b0;
    bus.readaddr = 5'd2; step();
    check("done_status", 32'(bus.readdata), 32'h00);

    // Priority: sources 5 and 2 together
    wr(5'd1, 8'hFF);
    bus.int_in = 8'h24; step();
    bus.int_in = 8'h00; step();
    check("prio_first_irq", 32'(bus.irq), 32'd1);
    check("prio_first_vec", 32'(bus.irq_vector), 32'd2);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    bus.irq_done = 1'b1; step(); bus.irq_done = 1'b0;
    step();
    check("prio_second_irq", 32'(bus.irq), 32'd1);
    check("prio_second_vec", 32'(bus.irq_vector), 32'd5);
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    bus.irq_done = 1'b1; step(); bus.irq_done = 1'b0;

    // Retract by masking while requesting vector 3
    bus.int_in = 8'h08; step();
    bus.int_in = 8'h00; step();
    check("retract_pre_vec", 32'(bus.irq_vector), 32'd3);
    wr(5'd1, 8'h00);
    check("retract_irq", 32'(bus.irq), 32'd0);
    bus.readaddr = 5'd0; step();
    check("retract_pending", 32'(bus.readdata), 32'h08);
    bus.readaddr = 5'd2; step();
    check("retract_status", 32'(bus.readdata), 32'h03);

    // Event and W1C on the same bit: set wins
    bus.int_in = 8'h10;
    wr(5'd0, 8'h10);
    bus.int_in = 8'h00;
    bus.readaddr = 5'd0; step();
    check("set_wins_pending", 32'(bus.readdata), 32'h18);
    wr(5'd0, 8'hFF);
    step();
    check("w1c_all_pending", 32'(bus.readdata), 32'h00);

    // Line held high for ten cycles
    wr(5'd1, 8'h02);
    services = 0;
    for (int i = 0; i < 20; i++) begin
      bus.int_in   = (i < 10) ? 8'h02 : 8'h00;
      if (bus.irq) services++;
      bus.irq_ack  = bus.irq;
      bus.irq_done = 1'b1;
      step();
    end
    bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
`ifdef INTR_EDGE_DETECT_EN
    check("held_services", 32'(services), 32'd1);
`else
    check("held_repends", 32'(services >= 2), 32'd1);
`endif

    // Reset during SERVICE with another source still pending
    wr(5'd1, 8'h01);
    bus.int_in = 8'h81; step();
    bus.int_in = 8'h00; step();
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
    bus.readaddr = 5'd0; step();
    check("pre_reset_pending", 32'(bus.readdata), 32'h80);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_reset_irq", 32'(bus.irq), 32'd0);
    check("mid_reset_readdata", 32'(bus.readdata), 32'd0);
    step();
    check("post_reset_pending", 32'(bus.readdata), 32'h00);
    bus.readaddr = 5'd1; step();
    check("post_reset_mask", 32'(bus.readdata), 32'h00);
    bus.readaddr = 5'd2; step();
    check("post_reset_status", 32'(bus.readdata), 32'h00);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.int_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bus.write_en  = ($urandom_range(0, 5) == 0);
      bus.writeaddr = 5'($urandom_range(0, 4));
      bus.writedata = 8'($urandom);
      bus.irq_ack   = ($urandom_range(0, 2) == 0);
      bus.irq_done  = ($urandom_range(0, 3) == 0);
      bus.readaddr  = 5'($urandom_range(0, 5));
      reset         = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; bus.write_en = 1'b0; bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
    bus.int_in = 8'h00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
